// File: rtl/sig_normalizer.sv
// sig_normalizer: normalizes four lanes of signed fixed-point adder results
// into sign / biased exponent / rounded mantissa, with overflow saturation
// and underflow flush. Three-stage lockstep pipeline with ready/valid flow.
module sig_normalizer #(
    parameter int expWidth   = 4,
    parameter int sigWidth   = 4,
    parameter int low_expand = 2,
    localparam int SW        = sigWidth + 4 + low_expand
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [3:0][SW-1:0]                 sum,
    input  logic [3:0][expWidth-1:0]           exp_max,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [3:0]                         sign_o,
    output logic [3:0][expWidth-1:0]           exp_o,
    output logic [3:0][sigWidth-1:0]           man_o,
    output logic [3:0]                         ovf_o,
    output logic [3:0]                         udf_o
);

    localparam int LANES = 4;
    localparam int H     = sigWidth + low_expand;
    localparam int EW2   = expWidth + 2;
    localparam int PW    = $clog2(SW);
    localparam int GB    = SW - 2 - sigWidth;   // guard bit position in the normalized word

    localparam logic signed [EW2-1:0] EMAX = EW2'((1 << expWidth) - 1);
    localparam logic signed [EW2-1:0] ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] HOFF = EW2'(H);

    typedef struct packed {
        logic                sign;
        logic [expWidth-1:0] exp;
        logic [sigWidth-1:0] man;
        logic                ovf;
        logic                udf;
    } res_t;

    // Index of the most significant set bit (0 when v is zero).
    function automatic logic [PW-1:0] lead_one(input logic [SW-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < SW; i++) begin
            if (v[i]) p = PW'(i);
        end
        return p;
    endfunction

    // Round-to-nearest-even; the MSB of the result is the mantissa carry-out.
    function automatic logic [sigWidth:0] round_rne(input logic [sigWidth-1:0] man,
                                                    input logic grd, input logic stk);
        logic inc;
        inc = grd & (stk | man[0]);
        return {1'b0, man} + (sigWidth+1)'(inc);
    endfunction

    // Zero / overflow-saturate / underflow-flush selection on the rounded exponent.
    function automatic res_t saturate(input logic sign, input logic zero,
                                      input logic signed [EW2-1:0] e,
                                      input logic [sigWidth-1:0] man);
        res_t r;
        r = '0;
        if (zero) begin
            r = '0;
        end else if (e > EMAX) begin
            r.sign = sign;
            r.exp  = '1;
            r.man  = '1;
            r.ovf  = 1'b1;
        end else if (e < ONE) begin
            r.udf  = 1'b1;
        end else begin
            r.sign = sign;
            r.exp  = e[expWidth-1:0];
            r.man  = man;
        end
        return r;
    endfunction

    logic adv;
    logic vld_p0, vld_p1;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---- stage 1: sign / magnitude ----
    logic                s1_sign [LANES];
    logic [SW-1:0]       s1_mag  [LANES];
    logic                sign_p0 [LANES];
    logic [SW-1:0]       mag_p0  [LANES];
    logic [expWidth-1:0] exp_p0  [LANES];

    // Magnitude keeps all SW bits so the most negative input maps to 2^(SW-1).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_sign[i] = sum[i][SW-1];
            s1_mag[i]  = s1_sign[i] ? (~sum[i] + SW'(1)) : sum[i];
        end
    end

    // Stage-1 data registers.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            for (int i = 0; i < LANES; i++) begin
                sign_p0[i] <= s1_sign[i];
                mag_p0[i]  <= s1_mag[i];
                exp_p0[i]  <= exp_max[i];
            end
        end
    end

    // ---- stage 2: leading-one detect and normalizing shift ----
    logic [PW-1:0]           s2_p    [LANES];
    logic [SW-1:0]           s2_norm [LANES];
    logic signed [EW2-1:0]   s2_e    [LANES];
    logic                    sign_p1 [LANES];
    logic                    zero_p1 [LANES];
    logic signed [EW2-1:0]   e_p1    [LANES];
    logic [sigWidth-1:0]     man_p1  [LANES];
    logic                    grd_p1  [LANES];
    logic                    stk_p1  [LANES];

    // Shift the leading one to the top bit; bits below it are mantissa, guard, sticky.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s2_p[i]    = lead_one(mag_p0[i]);
            s2_norm[i] = mag_p0[i] << (PW'(SW - 1) - s2_p[i]);
            s2_e[i]    = $signed({2'b00, exp_p0[i]}) + $signed(EW2'(s2_p[i])) - HOFF;
        end
    end

    // Stage-2 data registers.
    always_ff @(posedge clk) begin
        if (adv && vld_p0) begin
            for (int i = 0; i < LANES; i++) begin
                sign_p1[i] <= sign_p0[i];
                zero_p1[i] <= ~s2_norm[i][SW-1];
                e_p1[i]    <= s2_e[i];
                man_p1[i]  <= s2_norm[i][SW-2 -: sigWidth];
                grd_p1[i]  <= s2_norm[i][GB];
                stk_p1[i]  <= |s2_norm[i][GB-1:0];
            end
        end
    end

    // ---- stage 3: round, exponent adjust, saturate / flush ----
    logic [sigWidth:0]     s3_rnd [LANES];
    logic signed [EW2-1:0] s3_e   [LANES];
    res_t                  s3_res [LANES];

    // A rounding carry leaves the mantissa at zero and bumps the exponent.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s3_rnd[i] = round_rne(man_p1[i], grd_p1[i], stk_p1[i]);
            s3_e[i]   = s3_rnd[i][sigWidth] ? e_p1[i] + ONE : e_p1[i];
            s3_res[i] = saturate(sign_p1[i], zero_p1[i], s3_e[i], s3_rnd[i][sigWidth-1:0]);
        end
    end

    // Valid chain and output registers; everything holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            sign_o    <= '0;
            exp_o     <= '0;
            man_o     <= '0;
            ovf_o     <= '0;
            udf_o     <= '0;
        end else if (adv) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
            if (vld_p1) begin
                for (int i = 0; i < LANES; i++) begin
                    sign_o[i] <= s3_res[i].sign;
                    exp_o[i]  <= s3_res[i].exp;
                    man_o[i]  <= s3_res[i].man;
                    ovf_o[i]  <= s3_res[i].ovf;
                    udf_o[i]  <= s3_res[i].udf;
                end
            end
        end
    end

endmodule

// File: tb/tb_sig_normalizer.sv
// Testbench for sig_normalizer: table of per-lane vectors rotated across the
// four lanes, scoreboard queue checked at the output handshake, plus
// latency, stall, random backpressure and mid-flight reset sequences.
module tb_sig_normalizer;

    localparam int EW = 4;
    localparam int MW = 4;
    localparam int SW = 10;
    localparam int NV = 18;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0][SW-1:0]   sum;
    logic [3:0][EW-1:0]   exp_max;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           sign_o;
    logic [3:0][EW-1:0]   exp_o;
    logic [3:0][MW-1:0]   man_o;
    logic [3:0]           ovf_o;
    logic [3:0]           udf_o;

    sig_normalizer #(.expWidth(EW), .sigWidth(MW), .low_expand(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .exp_max  (exp_max),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sign_o   (sign_o),
        .exp_o    (exp_o),
        .man_o    (man_o),
        .ovf_o    (ovf_o),
        .udf_o    (udf_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic [EW-1:0] emax;
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] man;
        logic          ovf;
        logic          udf;
    } vec_t;

    typedef struct {
        logic [3:0]         sign;
        logic [3:0][EW-1:0] exp;
        logic [3:0][MW-1:0] man;
        logic [3:0]         ovf;
        logic [3:0]         udf;
        int                 id;
    } exp_t;

    vec_t vt [NV];
    exp_t sb [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   last_acc = 0;
    bit   bp_done  = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cmp_bundle(input exp_t e, input string tag);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("%s id%0d lane%0d sign", tag, e.id, l), int'(sign_o[l]), int'(e.sign[l]));
            chk($sformatf("%s id%0d lane%0d exp",  tag, e.id, l), int'(exp_o[l]),  int'(e.exp[l]));
            chk($sformatf("%s id%0d lane%0d man",  tag, e.id, l), int'(man_o[l]),  int'(e.man[l]));
            chk($sformatf("%s id%0d lane%0d ovf",  tag, e.id, l), int'(ovf_o[l]),  int'(e.ovf[l]));
            chk($sformatf("%s id%0d lane%0d udf",  tag, e.id, l), int'(udf_o[l]),  int'(e.udf[l]));
        end
    endtask

    // Called just after a rising edge; bundle k puts vector (k+l)%NV on lane l.
    task automatic send(input int k, output int waited);
        exp_t e;
        int   j;
        bit   acc;
        waited = 0;
        acc    = 1'b0;
        for (int l = 0; l < 4; l++) begin
            j          = (k + l) % NV;
            sum[l]     = vt[j].sum;
            exp_max[l] = vt[j].emax;
            e.sign[l]  = vt[j].sign;
            e.exp[l]   = vt[j].exp;
            e.man[l]   = vt[j].man;
            e.ovf[l]   = vt[j].ovf;
            e.udf[l]   = vt[j].udf;
        end
        e.id     = k;
        in_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                last_acc = cyc;
                acc      = 1'b1;
                break;
            end
            waited++;
        end
        if (!acc) chk($sformatf("accept_timeout id%0d", k), 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        chk("drain", sb.size(), 0);
        sync();
    endtask

    // Scoreboard consumer: compare at every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                cmp_bundle(mon_e, "out");
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lat;
        int c0;
        int n0;

        vt[0]  = '{10'h040, 4'd8,  1'b0, 4'd8,  4'd0,  1'b0, 1'b0};
        vt[1]  = '{10'h3C0, 4'd8,  1'b1, 4'd8,  4'd0,  1'b0, 1'b0};
        vt[2]  = '{10'h0C8, 4'd8,  1'b0, 4'd9,  4'd9,  1'b0, 1'b0};
        vt[3]  = '{10'h0C4, 4'd8,  1'b0, 4'd9,  4'd8,  1'b0, 1'b0};
        vt[4]  = '{10'h0CC, 4'd8,  1'b0, 4'd9,  4'd10, 1'b0, 1'b0};
        vt[5]  = '{10'h0FC, 4'd8,  1'b0, 4'd10, 4'd0,  1'b0, 1'b0};
        vt[6]  = '{10'h080, 4'd15, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0};
        vt[7]  = '{10'h020, 4'd1,  1'b0, 4'd0,  4'd0,  1'b0, 1'b1};
        vt[8]  = '{10'h000, 4'd7,  1'b0, 4'd0,  4'd0,  1'b0, 1'b0};
        vt[9]  = '{10'h200, 4'd5,  1'b1, 4'd8,  4'd0,  1'b0, 1'b0};
        vt[10] = '{10'h003, 4'd10, 1'b0, 4'd5,  4'd8,  1'b0, 1'b0};
        vt[11] = '{10'h33C, 4'd8,  1'b1, 4'd9,  4'd8,  1'b0, 1'b0};
        vt[12] = '{10'h0C5, 4'd8,  1'b0, 4'd9,  4'd9,  1'b0, 1'b0};
        vt[13] = '{10'h380, 4'd15, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0};
        vt[14] = '{10'h3E0, 4'd1,  1'b0, 4'd0,  4'd0,  1'b0, 1'b1};
        vt[15] = '{10'h0FC, 4'd14, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0};
        vt[16] = '{10'h03F, 4'd1,  1'b0, 4'd1,  4'd0,  1'b0, 1'b0};
        vt[17] = '{10'h1FF, 4'd3,  1'b0, 4'd6,  4'd0,  1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        exp_max   = '0;

        // Reset state
        #12;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst sign_o",    int'(sign_o),    0);
        chk("rst exp_o",     int'(exp_o),     0);
        chk("rst man_o",     int'(man_o),     0);
        chk("rst ovf_o",     int'(ovf_o),     0);
        chk("rst udf_o",     int'(udf_o),     0);
        chk("rst in_ready",  int'(in_ready),  1);
        sync();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sync();

        // Latency of a single bundle into an empty pipeline
        send(0, w);
        c0  = last_acc;
        lat = -1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - c0;
                break;
            end
        end
        chk("latency", lat, 3);
        sync();
        drain();

        // Full table, back-to-back, downstream always ready
        for (int k = 0; k < NV; k++) begin
            send(k, w);
            chk($sformatf("throughput wait id%0d", k), w, 0);
        end
        drain();

        // Three bundles then a 5-cycle downstream stall
        out_ready = 1'b0;
        n0 = n_out;
        for (int k = 3; k < 6; k++) begin
            send(k, w);
            chk($sformatf("fill wait id%0d", k), w, 0);
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall in_ready",  int'(in_ready),  0);
            chk("stall out_valid", int'(out_valid), 1);
            chk("stall depth",     sb.size(),       3);
            if (sb.size() > 0) cmp_bundle(sb[0], "stall");
        end
        sync();
        out_ready = 1'b1;
        drain();
        chk("stall results delivered", n_out - n0, 3);

        // Random backpressure over the table
        bp_done = 1'b0;
        fork
            begin
                for (int k = 0; k < NV; k++) send(k, w);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three bundles in flight
        for (int k = 6; k < 9; k++) send(k, w);
        chk("pre_reset busy", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst sign_o",    int'(sign_o),    0);
        chk("midrst exp_o",     int'(exp_o),     0);
        chk("midrst man_o",     int'(man_o),     0);
        chk("midrst ovf_o",     int'(ovf_o),     0);
        chk("midrst udf_o",     int'(udf_o),     0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst in_ready", int'(in_ready), 1);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("post_rst no stale", int'(out_valid), 0);
        end
        sync();

        // Recovery after reset
        send(9, w);
        drain();
        chk("scoreboard empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
